fetch_stage: RTL and testbench



---
 rtl/fetch_stage.sv | 127 ++++++++++++
 tb/tb_fetch_stage.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// RV32I instruction fetch stage: owns the PC, issues credit-limited word requests
// to instruction memory and buffers returned words for decode in a small FIFO.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid
  // never depends combinationally on ready, and the offered payload holds until taken.

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     pc_q;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   fifo_count_q;
  logic [PW-1:0]   fifo_head_q, fifo_tail_q;
  logic [PW-1:0]   pcq_head_q, pcq_tail_q;
  logic [31:0]     fifo_inst[DEPTH];
  logic [31:0]     fifo_pc[DEPTH];
  logic [31:0]     pcq[DEPTH];

  logic [CW:0]     credit_used;
  logic            acc;
  logic            rsp;
  logic            push;
  logic            pop;
  logic            unused_bits;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign unused_bits = ^redirect_pc[1:0];

  assign credit_used    = {1'b0, outst_q} + {1'b0, fifo_count_q};
  assign imem_req_valid = (state_q == FETCH) && (credit_used < (CW + 1)'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign acc            = imem_req_valid && imem_req_ready;
  // Responses in BOOT belong to requests issued before reset.
  assign rsp            = imem_rsp_valid && (state_q != BOOT);
  assign push           = rsp && (state_q == FETCH) && !redirect_valid;
  assign id_valid       = (fifo_count_q != '0);
  assign pop            = id_valid && id_ready && !redirect_valid;
  assign outst_d        = outst_q + CW'(acc) - CW'(rsp);

  assign id_inst   = id_valid ? fifo_inst[fifo_head_q] : NOP;
  assign id_pc     = id_valid ? fifo_pc[fifo_head_q] : 32'h0;
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = FETCH;
      FETCH:   if (redirect_valid && (outst_d != '0)) state_d = FLUSH;
      FLUSH:   if (outst_d == '0) state_d = FETCH;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      outst_q      <= '0;
      fifo_count_q <= '0;
      fifo_head_q  <= '0;
      fifo_tail_q  <= '0;
      pcq_head_q   <= '0;
      pcq_tail_q   <= '0;
    end else begin
      state_q <= state_d;
      outst_q <= outst_d;
      if (redirect_valid) pc_q <= {redirect_pc[31:2], 2'b00};
      else if (acc)       pc_q <= pc_q + 32'd4;
      // The PC queue tracks every in-flight request, stale ones included.
      if (acc) pcq_tail_q <= ptr_inc(pcq_tail_q);
      if (rsp) pcq_head_q <= ptr_inc(pcq_head_q);
      if (redirect_valid) begin
        fifo_count_q <= '0;
        fifo_head_q  <= '0;
        fifo_tail_q  <= '0;
      end else begin
        if (push) fifo_tail_q <= ptr_inc(fifo_tail_q);
        if (pop)  fifo_head_q <= ptr_inc(fifo_head_q);
        fifo_count_q <= fifo_count_q + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (acc) pcq[pcq_tail_q] <= pc_q;
    if (push) begin
      fifo_inst[fifo_tail_q] <= imem_rsp_data;
      fifo_pc[fifo_tail_q]   <= pcq[pcq_head_q];
    end
  end

  // A response with nothing outstanding means the memory broke the protocol.
  always @(posedge clk) begin
    if (!rst && rsp) assert (outst_q != '0);
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: an in-order memory model with programmable latency
// serves one of two instances (DEPTH=2 at PC 0, DEPTH=3 at PC 0xFFFF_FFF8).
module tb_fetch_stage;

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [31:0] XMASK  = 32'hA5A5_0000;

  logic clk;
  logic        rst_v[2], req_valid_v[2], req_ready_v[2], rsp_valid_v[2];
  logic        redirect_valid_v[2], id_valid_v[2], id_ready_v[2];
  logic [31:0] req_addr_v[2], rsp_data_v[2], redirect_pc_v[2], id_inst_v[2], id_pc_v[2];
  logic [1:0]  state_v[2];

  fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_d2 (
    .clk(clk), .rst(rst_v[0]),
    .imem_req_valid(req_valid_v[0]), .imem_req_ready(req_ready_v[0]), .imem_req_addr(req_addr_v[0]),
    .imem_rsp_valid(rsp_valid_v[0]), .imem_rsp_data(rsp_data_v[0]),
    .redirect_valid(redirect_valid_v[0]), .redirect_pc(redirect_pc_v[0]),
    .id_valid(id_valid_v[0]), .id_ready(id_ready_v[0]), .id_inst(id_inst_v[0]), .id_pc(id_pc_v[0]),
    .dbg_state(state_v[0])
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(3)) u_d3 (
    .clk(clk), .rst(rst_v[1]),
    .imem_req_valid(req_valid_v[1]), .imem_req_ready(req_ready_v[1]), .imem_req_addr(req_addr_v[1]),
    .imem_rsp_valid(rsp_valid_v[1]), .imem_rsp_data(rsp_data_v[1]),
    .redirect_valid(redirect_valid_v[1]), .redirect_pc(redirect_pc_v[1]),
    .id_valid(id_valid_v[1]), .id_ready(id_ready_v[1]), .id_inst(id_inst_v[1]), .id_pc(id_pc_v[1]),
    .dbg_state(state_v[1])
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // ---------------- stimulus state ----------------
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] due;
  } pend_t;

  int          ch;
  logic        rst, req_rdy, id_rdy, redir;
  logic [31:0] redir_pc;
  int          lat;
  logic [31:0] cyc;
  pend_t       pend[$];
  logic [31:0] acc_q[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_inst[$];
  logic [31:0] pop_cyc[$];
  logic [31:0] exp_q[$];

  int n_checks;
  int n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called mid-cycle with the cycle's inputs chosen; records what transfers on the
  // coming rising edge and returns at the next falling edge.
  task automatic cycle();
    pend_t p;
    logic  rsp;
    for (int k = 0; k < 2; k++) begin
      rst_v[k]            = (k != ch) || rst;
      req_ready_v[k]      = req_rdy;
      id_ready_v[k]       = id_rdy;
      redirect_valid_v[k] = (k == ch) && redir;
      redirect_pc_v[k]    = redir_pc;
    end
    if (rst) pend.delete();
    rsp = (pend.size() > 0) && (pend[0].due <= cyc);
    for (int k = 0; k < 2; k++) begin
      rsp_valid_v[k] = (k == ch) && rsp;
      rsp_data_v[k]  = rsp ? (pend[0].addr ^ XMASK) : 32'h0;
    end
    #1;
    if (!rst) begin
      if (rsp) void'(pend.pop_front());
      if (req_valid_v[ch] && req_rdy) begin
        acc_q.push_back(req_addr_v[ch]);
        p.addr = req_addr_v[ch];
        p.due  = cyc + 32'(lat);
        pend.push_back(p);
      end
      if (id_valid_v[ch] && id_rdy) begin
        pop_pc.push_back(id_pc_v[ch]);
        pop_inst.push_back(id_inst_v[ch]);
        pop_cyc.push_back(cyc);
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset(input int sel);
    ch = sel;
    rst = 1'b1; redir = 1'b0; req_rdy = 1'b1;
    cycle();
    rst = 1'b0;
    acc_q.delete(); pop_pc.delete(); pop_inst.delete(); pop_cyc.delete();
  endtask

  task automatic run_pops(input string tag, input int n, input int budget);
    int b;
    b = budget;
    while (pop_pc.size() < n && b > 0) begin cycle(); b--; end
    check(tag, pop_pc.size(), n);
  endtask

  function automatic logic [31:0] pc_at(input int i);
    return (pop_pc.size() > i) ? pop_pc[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] inst_at(input int i);
    return (pop_inst.size() > i) ? pop_inst[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] acc_at(input int i);
    return (acc_q.size() > i) ? acc_q[i] : 32'hDEAD_BEEF;
  endfunction

  // ---------------- tests ----------------
  initial begin
    logic [31:0] r1;
    logic [31:0] e;
    int pm, am;
    n_checks = 0; n_errors = 0; cyc = 0;
    ch = 0; rst = 1'b1; req_rdy = 1'b1; id_rdy = 1'b1; redir = 1'b0;
    redir_pc = 32'h0; lat = 1;

    // Reset values, then streaming with 1-cycle memory
    cycle();
    do_reset(0);
    check("rst_req_valid", req_valid_v[0], 0);
    check("rst_id_valid", id_valid_v[0], 0);
    check("rst_id_inst", id_inst_v[0], 32'h13);
    check("rst_id_pc", id_pc_v[0], 0);
    check("rst_state", state_v[0], S_BOOT);
    r1 = cyc;
    cycle();
    check("first_req_valid", req_valid_v[0], 1);
    check("first_req_addr", req_addr_v[0], 32'h0);
    check("fetch_state", state_v[0], S_FETCH);
    for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
    run_pops("stream_count", 6, 40);
    for (int i = 0; i < 6; i++) begin
      e = exp_q.pop_front();
      check("stream_pc", pc_at(i), e);
      check("stream_inst", inst_at(i), e ^ XMASK);
    end
    check("first_pop_cycle", (pop_cyc.size() > 0) ? pop_cyc[0] : 32'hDEAD_BEEF, r1 + 3);

    // Backpressure
    do_reset(0);
    id_rdy = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    check("bp_acc_count", acc_q.size(), 2);
    check("bp_req_valid", req_valid_v[0], 0);
    check("bp_id_valid", id_valid_v[0], 1);
    check("bp_head_pc", id_pc_v[0], 32'h0);
    check("bp_head_inst", id_inst_v[0], XMASK);
    id_rdy = 1'b1;
    run_pops("bp_pop_count", 3, 30);
    check("bp_pc0", pc_at(0), 32'h0);
    check("bp_pc1", pc_at(1), 32'h4);
    check("bp_pc2", pc_at(2), 32'h8);
    check("bp_inst2", inst_at(2), 32'h8 ^ XMASK);

    // Redirect with two requests in flight, 3-cycle memory
    do_reset(0);
    lat = 3; id_rdy = 1'b1;
    cycle(); cycle(); cycle();
    check("rd_outstanding", acc_q.size(), 2);
    check("rd_req_blocked", req_valid_v[0], 0);
    redir = 1'b1; redir_pc = 32'h0000_0103;
    cycle();
    redir = 1'b0;
    check("rd_state_flush", state_v[0], S_FLUSH);
    check("rd_req_addr", req_addr_v[0], 32'h0000_0100);
    check("rd_flush_no_req", req_valid_v[0], 0);
    run_pops("rd_pop_count", 1, 30);
    check("rd_next_acc", acc_at(2), 32'h0000_0100);
    check("rd_first_pc", pc_at(0), 32'h0000_0100);
    check("rd_first_inst", inst_at(0), 32'h0000_0100 ^ XMASK);

    // PC wrap on the DEPTH=3 instance
    do_reset(1);
    lat = 1; id_rdy = 1'b1;
    run_pops("wrap_pop_count", 3, 30);
    check("wrap_acc0", acc_at(0), 32'hFFFF_FFF8);
    check("wrap_acc1", acc_at(1), 32'hFFFF_FFFC);
    check("wrap_acc2", acc_at(2), 32'h0000_0000);
    check("wrap_pc2", pc_at(2), 32'h0000_0000);

    // Redirect, response, acceptance and pop all in one cycle (DEPTH=3)
    do_reset(1);
    lat = 2; id_rdy = 1'b0; req_rdy = 1'b1;
    cycle(); cycle(); cycle();
    req_rdy = 1'b0;
    cycle();
    req_rdy = 1'b1; id_rdy = 1'b1; redir = 1'b1; redir_pc = 32'h0000_2000;
    check("sim_pre_id_valid", id_valid_v[1], 1);
    check("sim_pre_req_valid", req_valid_v[1], 1);
    cycle();
    redir = 1'b0;
    check("sim_id_valid", id_valid_v[1], 0);
    check("sim_id_inst", id_inst_v[1], 32'h13);
    check("sim_state_flush", state_v[1], S_FLUSH);
    check("sim_pc", req_addr_v[1], 32'h0000_2000);
    check("sim_stale_acc", acc_at(2), 32'h0000_0000);
    pm = pop_pc.size();
    am = acc_q.size();
    cycle();
    check("sim_still_flush", state_v[1], S_FLUSH);
    cycle();
    check("sim_back_fetch", state_v[1], S_FETCH);
    check("sim_req_valid", req_valid_v[1], 1);
    run_pops("sim_pop_count", pm + 1, 20);
    check("sim_next_acc", acc_at(am), 32'h0000_2000);
    check("sim_first_pc", pc_at(pm), 32'h0000_2000);

    // Reset with a full FIFO
    do_reset(0);
    lat = 1; id_rdy = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    check("mr_pre_id_valid", id_valid_v[0], 1);
    check("mr_pre_req_valid", req_valid_v[0], 0);
    do_reset(0);
    check("mr_id_valid", id_valid_v[0], 0);
    check("mr_id_inst", id_inst_v[0], 32'h13);
    check("mr_req_valid", req_valid_v[0], 0);
    check("mr_state", state_v[0], S_BOOT);
    id_rdy = 1'b1;
    cycle();
    check("mr_restart_valid", req_valid_v[0], 1);
    check("mr_restart_addr", req_addr_v[0], 32'h0);
    run_pops("mr_pop_count", 1, 20);
    check("mr_first_pc", pc_at(0), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
